// File: rtl/div_16bits_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_16bits_pkg
// Purpose  : Shared ALU divider definitions: FSM state encoding, default
//            operand width and the divide-by-zero quotient value.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package div_16bits_pkg;

    // Default operand / quotient / remainder width in bits
    localparam int unsigned c_width_default = 16;

    // Divide-by-zero quotient (all ones); wide enough for any supported
    // WIDTH, users take the low WIDTH bits.
    localparam logic [63:0] c_div_zero_quotient = '1;

    // Divider control state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : div_16bits_pkg
`default_nettype wire

// File: rtl/div_16bits_if.sv
`default_nettype none
// ============================================================================
// Module   : div_16bits_if
// Purpose  : Request/result bundle between a requester and the divider.
// Ports    : start, dividend, divisor      (requester -> divider)
//            busy, done, quotient,
//            remainder, div_zero           (divider -> requester)
//            modport master : requester side
//            modport slave  : divider side
// Revision : 1.0 - initial release
// ============================================================================
interface div_16bits_if
    import div_16bits_pkg::*;
#(
    parameter int WIDTH = c_width_default
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_zero
    );

endinterface : div_16bits_if
`default_nettype wire

// File: rtl/div_16bits_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring-division step. Shifts the next
//            dividend bit into the partial remainder, trial-subtracts the
//            divisor with the subtractor form (B inverted, carry-in 1) and
//            keeps the difference only when it is non-negative.
// Ports    : r       in  WIDTH+1  partial remainder
//            q_msb   in  1        dividend bit shifted in this step
//            d       in  WIDTH    divisor
//            r_next  out WIDTH+1  partial remainder after the step
//            q_bit   out 1        quotient bit produced by the step
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 16
) (
    input  wire logic [WIDTH:0]   r,
    input  wire logic             q_msb,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH:0]   r_next,
    output logic                  q_bit
);

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_sub_b;
    logic [WIDTH+1:0] w_sum;
    logic             w_carry;
    logic             w_nonneg;

    always_comb begin
        w_shifted = {r[WIDTH-1:0], q_msb};
        // Subtract as A + ~B + 1; the carry out of the WIDTH+1 bit adder is
        // set exactly when A >= B.
        w_sub_b   = ~{1'b0, d};
        w_sum     = {1'b0, w_shifted} + {1'b0, w_sub_b} + {{(WIDTH+1){1'b0}}, 1'b1};
        w_carry   = w_sum[WIDTH+1];
        // A set top bit of r would be shifted out of the window; the true
        // trial value is then larger than any divisor, so it counts as
        // non-negative. The invariant r < d keeps this bit at 0 in practice.
        w_nonneg  = w_carry | r[WIDTH];
        r_next    = w_nonneg ? w_sum[WIDTH:0] : w_shifted;
        q_bit     = w_nonneg;
    end

endmodule : div_step
`default_nettype wire

// File: rtl/div_16bits.sv
`default_nettype none
// ============================================================================
// Module   : div_16bits
// Purpose  : Sequential unsigned restoring divider. Accepts an operand pair
//            on start in IDLE, performs one trial-subtract-and-shift step per
//            clock and presents quotient/remainder with a one-cycle done
//            pulse. Divide by zero completes in one cycle with quotient all
//            ones, remainder = dividend and div_zero set.
// Ports    : clk   in  rising-edge clock
//            rst   in  asynchronous active-high reset
//            bus   slave modport of div_16bits_if
//                  (start/dividend/divisor in; busy/done/quotient/
//                   remainder/div_zero out, all registered)
// Revision : 1.0 - initial release
// ============================================================================
module div_16bits
    import div_16bits_pkg::*;
#(
    parameter int WIDTH = c_width_default
) (
    input  wire logic  clk,
    input  wire logic  rst,
    div_16bits_if.slave bus
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH:0]     r_r;
    logic [WIDTH-1:0]   r_d;
    logic [c_cnt_w-1:0] r_cnt;

    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_zero;

    logic [WIDTH:0]     w_r_next;
    logic               w_q_bit;
    logic [WIDTH-1:0]   w_q_next;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r      (r_r),
        .q_msb  (r_q[WIDTH-1]),
        .d      (r_d),
        .r_next (w_r_next),
        .q_bit  (w_q_bit)
    );

    // Q shifts left each step: its MSB feeds the remainder, the new
    // quotient bit enters at the LSB.
    assign w_q_next = {r_q[WIDTH-2:0], w_q_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_q         <= '0;
            r_r         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_q    <= bus.dividend;
                        r_d    <= bus.divisor;
                        r_r    <= '0;
                        r_cnt  <= c_cnt_w'(WIDTH - 1);
                        r_busy <= 1'b1;
                        if (bus.divisor == '0) begin
                            // No iteration needed: results are known now
                            r_state     <= DONE;
                            r_done      <= 1'b1;
                            r_quotient  <= c_div_zero_quotient[WIDTH-1:0];
                            r_remainder <= bus.dividend;
                            r_div_zero  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end

                RUN: begin
                    r_r   <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - c_cnt_w'(1);
                    if (r_cnt == '0) begin
                        // Last step: publish the step outputs directly so the
                        // result registers never hold partial values.
                        r_state     <= DONE;
                        r_done      <= 1'b1;
                        r_quotient  <= w_q_next;
                        r_remainder <= w_r_next[WIDTH-1:0];
                        r_div_zero  <= 1'b0;
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.div_zero  = r_div_zero;

endmodule : div_16bits
`default_nettype wire

// File: tb/tb_div_16bits.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_16bits
// Purpose  : Self-checking bench for div_16bits: directed operand pairs with
//            hand-computed results, latency/pulse/busy timing, back-to-back
//            operation, start during RUN, mid-run reset, divide by zero and a
//            short randomized sweep against the / and % operators.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_16bits;

    logic clk;
    logic rst;

    int n_checks;
    int n_pass;

    div_16bits_if #(.WIDTH(16)) bus ();

    div_16bits #(
        .WIDTH (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until done is seen; 0 means done is already high.
    task automatic wait_done(output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        while (!found && cycles < 40) begin
            if (bus.done === 1'b1) begin
                found = 1'b1;
            end else begin
                tick();
                cycles++;
            end
        end
        if (!found) check("done_timeout", 32'd0, 32'd1);
    endtask

    // One operation. lat = edges from the accepting edge to done.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic ez,
                          input int lat, input bit full);
        int cyc;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start = 1'b0;
        if (full) check({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
        wait_done(cyc);
        if (full) begin
            check({tag, "_latency"}, 32'(cyc), 32'(lat));
            check({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
        end
        check({tag, "_q"}, 32'(bus.quotient), 32'(eq));
        check({tag, "_r"}, 32'(bus.remainder), 32'(er));
        check({tag, "_z"}, 32'(bus.div_zero), 32'(ez));
        tick();
        if (full) begin
            check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
            check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        int cyc;
        int per;
        logic [15:0] ra;
        logic [15:0] rb;

        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_q", 32'(bus.quotient), 32'd0);
        check("rst_r", 32'(bus.remainder), 32'd0);
        check("rst_z", 32'(bus.div_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_op("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16, 1'b1);
        run_op("d5_9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 16, 1'b1);
        run_op("d0_3", 16'd0, 16'd3, 16'd0, 16'd0, 1'b0, 16, 1'b1);
        run_op("dz1234", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 0, 1'b1);
        run_op("d7_3", 16'd7, 16'd3, 16'd2, 16'd1, 1'b0, 16, 1'b1);

        // Back-to-back with start held high; second operands applied during RUN
        bus.start    = 1'b1;
        bus.dividend = 16'hFFFF;
        bus.divisor  = 16'd1;
        tick();
        bus.divisor  = 16'hFFFF;
        wait_done(cyc);
        check("b2b_first_latency", 32'(cyc), 32'd16);
        check("b2b_first_q", 32'(bus.quotient), 32'hFFFF);
        check("b2b_first_r", 32'(bus.remainder), 32'd0);
        per = 0;
        do begin
            tick();
            per++;
        end while (bus.done !== 1'b1 && per < 40);
        check("b2b_period", 32'(per), 32'd18);
        check("b2b_second_q", 32'(bus.quotient), 32'd1);
        check("b2b_second_r", 32'(bus.remainder), 32'd0);
        bus.start = 1'b0;
        tick();
        tick();

        // Start with different operands during RUN must be ignored
        bus.start    = 1'b1;
        bus.dividend = 16'd100;
        bus.divisor  = 16'd7;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.start    = 1'b1;
        bus.dividend = 16'd9;
        bus.divisor  = 16'd2;
        tick();
        bus.start = 1'b0;
        wait_done(cyc);
        check("runstart_latency", 32'(cyc), 32'd12);
        check("runstart_q", 32'(bus.quotient), 32'd14);
        check("runstart_r", 32'(bus.remainder), 32'd2);
        tick();

        // Asynchronous reset mid-run
        bus.start    = 1'b1;
        bus.dividend = 16'd100;
        bus.divisor  = 16'd7;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_q", 32'(bus.quotient), 32'd0);
        check("midrst_r", 32'(bus.remainder), 32'd0);
        repeat (3) tick();
        check("midrst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        per = 0;
        repeat (20) begin
            tick();
            if (bus.done === 1'b1) per++;
        end
        check("midrst_no_done", 32'(per), 32'd0);
        run_op("d50_6", 16'd50, 16'd6, 16'd8, 16'd2, 1'b0, 16, 1'b1);

        // Randomized sweep against the language operators
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            case (i % 4)
                0:       rb = 16'($urandom);
                1:       rb = 16'($urandom_range(1, 255));
                2:       rb = 16'($urandom_range(0, 3));
                default: rb = 16'($urandom_range(1, 65535));
            endcase
            if (rb == 16'd0)
                run_op("rnd", ra, rb, 16'hFFFF, ra, 1'b1, 0, 1'b0);
            else
                run_op("rnd", ra, rb, ra / rb, ra % rb, 1'b0, 16, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_div_16bits
`default_nettype wire
